bitstream_serializer: RTL
=========================

# bitstream_serializer

Parallel-to-serial front end that feeds the sequence detector's serial input `x`. Accepts WIDTH-bit words over a valid/ready handshake and emits them MSB first, one bit per `clk`, with a one-word holding buffer so consecutive words stream without gaps. Replaces hand-driven bit loops in benches and system glue: its `x` output connects directly to the detector's `x` input.

## Interface
- `WIDTH`, default 32: word width in bits, ≥ 2.
- `CNT_W`, default 8: width of the completed-word counter.

- `clk`  in  1  system clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_data`  in  WIDTH  word to serialize, bit WIDTH-1 sent first.
- `load_valid`  in  1  `load_data` is valid this cycle.
- `load_ready`  out  1  block can accept a word this cycle.
- `x`  out  1  serial data bit, registered.
- `x_valid`  out  1  `x` carries a real bit this cycle.
- `last`  out  1  high while `x` carries bit 0 of a word.
- `word_count`  out  CNT_W  number of fully transmitted words, wraps modulo 2^CNT_W.

## Operation
- Accept: a word transfers on a rising edge where `load_valid && load_ready`. `load_ready = !hold_full` (combinational from the register); forced 0 while `rst` is high.
- State: `shreg` (WIDTH), `bitcnt` (clog2(WIDTH)), `hold_reg` (WIDTH), `hold_full`, FSM {IDLE, SHIFT}.
- `x = shreg[WIDTH-1]` in SHIFT, 0 in IDLE. `x_valid` = (state == SHIFT). `last` = SHIFT && `bitcnt == WIDTH-1`.
- IDLE: accepted word loads `shreg` directly, `bitcnt <= 0`, go SHIFT. `hold_full` is always 0 in IDLE.
- SHIFT, not last bit: `shreg <= shreg << 1`, `bitcnt++`. An accepted word goes to `hold_reg`, `hold_full <= 1`.
- SHIFT, last bit (`bitcnt == WIDTH-1`), priority order:
  - `hold_full`: `shreg <= hold_reg`, `hold_full <= 0`, `bitcnt <= 0`, stay SHIFT.
  - else accepted word: bypass to `shreg`, `bitcnt <= 0`, stay SHIFT; `hold_full` stays 0.
  - else: go IDLE, `shreg <= 0`.
  - In all three cases `word_count++` (wraps).
- `load_valid` without `load_ready` has no effect; `load_data` is sampled only on the accept edge.

## Timing
- Reset values (async, immediate): state IDLE, `shreg`, `hold_reg`, `bitcnt`, `word_count` = 0, `hold_full` = 0. Outputs: `x` = 0, `x_valid` = 0, `last` = 0, `load_ready` = 0 while `rst` is high, 1 from the first cycle after release.
- Latency: word accepted at edge N, so bit WIDTH-1 appears on `x` with `x_valid` = 1 during cycle N..N+1. Bit 0 appears during cycle N+WIDTH-1, with `last` = 1.
- Throughput: one bit per cycle. Back-to-back words have no idle cycle if the next word is accepted on or before the last-bit edge.
- `word_count` increments on the edge that ends the `last` cycle.
- Holding buffer full: `load_ready` = 0 until the last-bit edge of the current word, then 1 in the following cycle.
- Reset mid-word: the word in flight and the held word are discarded. No partial `last` and no count increment.
- WIDTH = 2: `last` alternates every other cycle under continuous load. The bypass path must still hold.

## Test plan
- Single word: after reset, load 32'h69D1BC2E once. `x` must give 0,1,1,0,1,0,0,1,… (32 bits, MSB first) over 32 consecutive cycles with `x_valid` = 1. `last` = 1 only on the 32nd bit. Then IDLE with `x` = 0 and `x_valid` = 0, and `word_count` = 1.
- Back-to-back: load 32'hFFFF0000, then immediately 32'h0000FFFF (goes into the hold buffer). Require 64 gap-free valid bits, `load_ready` = 0 from the second accept until the first word's last edge, and `word_count` = 2.
- Bypass: load A = 32'hAAAAAAAA, then present B = 32'h55555555 only in the cycle where `last` = 1. B's MSB (0) must follow A's LSB (0) with no gap, and `hold_full` must never be set.
- Stall: hold `load_valid` = 1 with three words queued. Exactly one word transfers per accept edge, none are lost or duplicated, and the output sequence matches the input order.
- Reset mid-word: assert `rst` at bit 10 of a word with the hold buffer full. `x`, `x_valid` and `last` must drop to 0 immediately, `word_count` = 0, and the next load must serialize correctly from its MSB.
- Counter wrap (CNT_W = 2): send 5 words. `word_count` must read 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/bitstream_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, MSB-first
// serial stream out, with a one-word holding buffer for gap-free streaming.
module bitstream_serializer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x,
  output logic             x_valid,
  output logic             last,
  output logic [CNT_W-1:0] word_count
);

  localparam int            BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   shreg, shreg_nxt;
  logic [WIDTH-1:0]   hold_reg, hold_nxt;
  logic [BW-1:0]      bitcnt, bitcnt_nxt;
  logic               hold_full, hold_full_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               accept;
  logic               at_last;

  // Ready is held low during reset so nothing can be accepted on release.
  assign load_ready = !hold_full && !rst;
  assign accept     = load_valid && load_ready;
  assign at_last    = (state == SHIFT) && (bitcnt == LAST_IDX);
  assign x          = (state == SHIFT) ? shreg[WIDTH-1] : 1'b0;
  assign x_valid    = (state == SHIFT);
  assign last       = at_last;

  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    hold_nxt      = hold_reg;
    bitcnt_nxt    = bitcnt;
    hold_full_nxt = hold_full;
    cnt_nxt       = word_count;
    case (state)
      IDLE: begin
        if (accept) begin
          shreg_nxt  = load_data;
          bitcnt_nxt = '0;
          state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        if (!at_last) begin
          shreg_nxt  = shreg << 1;
          bitcnt_nxt = bitcnt + BW'(1);
          if (accept) begin
            hold_nxt      = load_data;
            hold_full_nxt = 1'b1;
          end
        end else begin
          // Last bit: held word wins, then a same-cycle bypass, else go idle.
          cnt_nxt    = word_count + CNT_W'(1);
          bitcnt_nxt = '0;
          if (hold_full) begin
            shreg_nxt     = hold_reg;
            hold_full_nxt = 1'b0;
          end else if (accept) begin
            shreg_nxt = load_data;
          end else begin
            shreg_nxt = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      hold_reg   <= '0;
      bitcnt     <= '0;
      hold_full  <= 1'b0;
      word_count <= '0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      hold_reg   <= hold_nxt;
      bitcnt     <= bitcnt_nxt;
      hold_full  <= hold_full_nxt;
      word_count <= cnt_nxt;
    end
  end

endmodule
